// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with EX/MEM forwarding, load-use bubble, flush/hold and stall counter
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [3:0]  id_alu_op,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [31:0] id_rs1_val,
  input  logic [31:0] id_rs2_val,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic        id_writes_rd,
  input  logic        id_is_load,
  input  logic [31:0] alu_out,
  input  logic        mem_valid,
  input  logic        mem_writes_rd,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_value,
  input  logic        flush,
  input  logic        hold,
  output logic        ex_valid,
  output logic        ex_writes_rd,
  output logic        ex_is_load,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        id_stall,
  output logic [31:0] stall_cycles
);
  localparam logic [3:0] ALU_ADD = 4'd0;
  logic        r_valid, r_writes_rd, r_is_load;
  logic [3:0]  r_alu_op;
  logic [31:0] r_a, r_b, r_store_data, r_stall_cycles;
  logic [4:0]  r_rd;
  logic        w_ex_fwd, w_load_use, w_bubble;
  logic [31:0] w_fwd1, w_fwd2;
  // Operand forwarding: EX (non-load) beats MEM beats register file; x0 never forwards.
  // alu_out feeds this mux in the same cycle, so ALU -> fwd -> ex_a/ex_b is the critical path.
  always_comb begin
    w_ex_fwd   = r_valid & r_writes_rd & !r_is_load;
    w_fwd1     = (w_ex_fwd & r_rd == id_rs1 & id_rs1 != 5'd0) ? alu_out :
                 (mem_valid & mem_writes_rd & mem_rd == id_rs1 & id_rs1 != 5'd0) ? mem_value : id_rs1_val;
    w_fwd2     = (w_ex_fwd & r_rd == id_rs2 & id_rs2 != 5'd0) ? alu_out :
                 (mem_valid & mem_writes_rd & mem_rd == id_rs2 & id_rs2 != 5'd0) ? mem_value : id_rs2_val;
    w_load_use = id_valid & r_valid & r_is_load & r_rd != 5'd0 &
                 ((id_uses_rs1 & id_rs1 == r_rd) | (id_uses_rs2 & id_rs2 == r_rd));
    w_bubble   = flush | (!hold & w_load_use);
    id_stall   = !flush & (hold | w_load_use);
  end
  // Pipeline register: bubble on flush or load-use, freeze on hold, otherwise capture decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset || w_bubble) begin
      r_valid      <= 1'b0;
      r_writes_rd  <= 1'b0;
      r_is_load    <= 1'b0;
      r_alu_op     <= ALU_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
    end else if (!hold) begin
      r_valid      <= id_valid;
      r_writes_rd  <= id_valid & id_writes_rd;
      r_is_load    <= id_is_load;
      r_alu_op     <= id_alu_op;
      r_a          <= w_fwd1;
      r_b          <= id_use_imm ? id_imm : w_fwd2;
      r_store_data <= w_fwd2;
      r_rd         <= id_rd;
    end
  end
  // Count only bubbles inserted for load-use, never hold or flush stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stall_cycles <= '0;
    else if (!flush && !hold && w_load_use) r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign ex_valid      = r_valid;
  assign ex_writes_rd  = r_writes_rd;
  assign ex_is_load    = r_is_load;
  assign ex_alu_op     = r_alu_op;
  assign ex_a          = r_a;
  assign ex_b          = r_b;
  assign ex_store_data = r_store_data;
  assign ex_rd         = r_rd;
  assign stall_cycles  = r_stall_cycles;
endmodule
